// File: rtl/netwalk_dp_pkg.sv
// Shared constants, FSM state type and the ternary-match helper for the
// netwalk match-action data plane.
package netwalk_dp_pkg;

    localparam int NUM_ENTRIES = 64;
    localparam int ADDR_W      = 6;
    localparam int KEY_W       = 356;
    localparam int EXEC_W      = 372;
    localparam int PCIE_W      = 128;
    localparam int PKT_WORDS   = 3;
    localparam int HDR_W       = PCIE_W * PKT_WORDS;
    localparam int FIFO_DEPTH  = 16;
    localparam int CNT_W       = 5;
    localparam int ACT_DROP    = 0;
    localparam int ACT_REWRITE = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LOOKUP  = 2'd2,
        ST_EMIT    = 2'd3
    } dp_state_e;

    function automatic logic masked_match(input logic [KEY_W-1:0] key,
                                          input logic [KEY_W-1:0] data,
                                          input logic [KEY_W-1:0] mask);
        return ((key & mask) == (data & mask));
    endfunction

endpackage

// File: rtl/netwalk_sync_fifo.sv
// Single-clock FIFO with show-ahead head word, occupancy count and
// registered full/empty flags.
module netwalk_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_s, pop_s;

    // Next-state pointers, count and flags; flags are derived from the next count.
    always_comb begin
        push_s   = wr_en && !full_q;
        pop_s    = rd_en && !empty_q;
        wr_ptr_d = push_s ? ((wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1))
                          : wr_ptr_q;
        rd_ptr_d = pop_s  ? ((rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1))
                          : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/netwalk_dataplane_subsystem.sv
// Match-action data plane: assembles 3-word headers from ingress, looks them up
// in a 64-entry ternary rule table, applies drop/rewrite and streams to egress.
module netwalk_dataplane_subsystem
    import netwalk_dp_pkg::*;
(
    input  logic               dpl_clk,
    input  logic               dpl_reset,
    input  logic [ADDR_W-1:0]  dpl_program_addr,
    input  logic [KEY_W-1:0]   dpl_program_data,
    input  logic [KEY_W-1:0]   dpl_program_mask,
    input  logic [EXEC_W-1:0]  dpl_exec_data,
    input  logic               dpl_program_enable,
    input  logic               dpl_delete_enable,
    input  logic               ingress_pcie_clk_i,
    input  logic               ingress_pcie_rst_i,
    input  logic [PCIE_W-1:0]  ingress_pcie_data_i,
    input  logic               ingress_pcie_wr_en_i,
    output logic               ingress_pcie_full_o,
    input  logic               egress_pcie_clk_i,
    output logic [PCIE_W-1:0]  egress_pcie_data_o,
    input  logic               egress_pcie_rd_i,
    output logic               egress_pcie_empty_o,
    output logic               egress_pcie_valid_o
);
    logic                   rst_s;
    logic [KEY_W-1:0]       rule_data_q [NUM_ENTRIES];
    logic [KEY_W-1:0]       rule_mask_q [NUM_ENTRIES];
    logic [EXEC_W-1:0]      rule_exec_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] rule_valid_q, rule_valid_d;

    dp_state_e              state_q, state_d;
    logic [1:0]             word_cnt_q, word_cnt_d;
    logic [HDR_W-1:0]       hdr_q, hdr_d;
    logic [PCIE_W-1:0]      eg_data_q, eg_data_d;
    logic                   eg_valid_q, eg_valid_d;

    logic                   hit_s, drop_s, rewrite_s;
    logic [ADDR_W-1:0]      hit_idx_s;
    logic [EXEC_W-1:0]      exec_sel_s;
    logic [EXEC_W-KEY_W-1:0] act_s;

    logic [PCIE_W-1:0]      in_head_s, eg_head_s, eg_wr_data_s;
    logic [CNT_W-1:0]       in_count_s, eg_count_s;
    logic                   in_full_s, in_empty_s, eg_full_s, eg_empty_s;
    logic                   in_pop_s, eg_push_s, eg_pop_s;
    logic                   unused_s;

    assign rst_s = dpl_reset | ingress_pcie_rst_i;

    netwalk_sync_fifo #(.WIDTH(PCIE_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_ingress_fifo (
        .clk     (dpl_clk),
        .rst     (rst_s),
        .wr_en   (ingress_pcie_wr_en_i),
        .wr_data (ingress_pcie_data_i),
        .rd_en   (in_pop_s),
        .head    (in_head_s),
        .count   (in_count_s),
        .full    (in_full_s),
        .empty   (in_empty_s)
    );

    netwalk_sync_fifo #(.WIDTH(PCIE_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_egress_fifo (
        .clk     (dpl_clk),
        .rst     (rst_s),
        .wr_en   (eg_push_s),
        .wr_data (eg_wr_data_s),
        .rd_en   (eg_pop_s),
        .head    (eg_head_s),
        .count   (eg_count_s),
        .full    (eg_full_s),
        .empty   (eg_empty_s)
    );

    // Rule payload storage; only the valid bits need a reset value.
    always_ff @(posedge dpl_clk) begin
        if (dpl_program_enable) begin
            rule_data_q[dpl_program_addr] <= dpl_program_data;
            rule_mask_q[dpl_program_addr] <= dpl_program_mask;
            rule_exec_q[dpl_program_addr] <= dpl_exec_data;
        end
    end

    // Valid-bit update: delete overrides a simultaneous program.
    always_comb begin
        rule_valid_d = rule_valid_q;
        if (dpl_delete_enable) begin
            rule_valid_d[dpl_program_addr] = 1'b0;
        end else if (dpl_program_enable) begin
            rule_valid_d[dpl_program_addr] = 1'b1;
        end else begin
            rule_valid_d = rule_valid_q;
        end
    end

    // Ternary lookup; scanning downward leaves the lowest hitting index.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = ADDR_W'(0);
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (rule_valid_q[i] && masked_match(hdr_q[KEY_W-1:0], rule_data_q[i], rule_mask_q[i])) begin
                hit_s     = 1'b1;
                hit_idx_s = ADDR_W'(i);
            end else begin
                hit_s     = hit_s;
            end
        end
        exec_sel_s = rule_exec_q[hit_idx_s];
        act_s      = exec_sel_s[EXEC_W-1:KEY_W];
        drop_s     = hit_s && act_s[ACT_DROP];
        rewrite_s  = hit_s && act_s[ACT_REWRITE] && !act_s[ACT_DROP];
    end

    // Packet FSM next-state logic: collect, look up, emit.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        hdr_d        = hdr_q;
        in_pop_s     = 1'b0;
        eg_push_s    = 1'b0;
        eg_wr_data_s = hdr_q[32'(word_cnt_q) * PCIE_W +: PCIE_W];
        case (state_q)
            ST_IDLE: begin
                if (!in_empty_s && (eg_count_s <= CNT_W'(FIFO_DEPTH - PKT_WORDS))) begin
                    state_d    = ST_COLLECT;
                    word_cnt_d = 2'd0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (!in_empty_s) begin
                    in_pop_s = 1'b1;
                    hdr_d[32'(word_cnt_q) * PCIE_W +: PCIE_W] = in_head_s;
                    if (word_cnt_q == 2'(PKT_WORDS - 1)) begin
                        state_d = ST_LOOKUP;
                    end else begin
                        word_cnt_d = word_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_LOOKUP: begin
                word_cnt_d = 2'd0;
                if (drop_s) begin
                    state_d = ST_IDLE;
                end else if (rewrite_s) begin
                    hdr_d[KEY_W-1:0] = exec_sel_s[KEY_W-1:0];
                    state_d          = ST_EMIT;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                eg_push_s = 1'b1;
                if (word_cnt_q == 2'(PKT_WORDS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    word_cnt_d = word_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Egress read port: a successful pop loads the output word for one valid cycle.
    always_comb begin
        eg_pop_s   = egress_pcie_rd_i && !eg_empty_s;
        eg_valid_d = eg_pop_s;
        eg_data_d  = eg_pop_s ? eg_head_s : eg_data_q;
    end

    // FSM state, header buffer, rule valid bits and egress output registers.
    always_ff @(posedge dpl_clk or posedge rst_s) begin
        if (rst_s) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= 2'd0;
            hdr_q        <= HDR_W'(0);
            rule_valid_q <= NUM_ENTRIES'(0);
            eg_data_q    <= PCIE_W'(0);
            eg_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            hdr_q        <= hdr_d;
            rule_valid_q <= rule_valid_d;
            eg_data_q    <= eg_data_d;
            eg_valid_q   <= eg_valid_d;
        end
    end

    assign ingress_pcie_full_o = in_full_s;
    assign egress_pcie_empty_o = eg_empty_s;
    assign egress_pcie_valid_o = eg_valid_q;
    assign egress_pcie_data_o  = eg_data_q;

    // Side clocks share dpl_clk; the ingress count and spare action bits are informational.
    assign unused_s = ^{ingress_pcie_clk_i, egress_pcie_clk_i, in_count_s, eg_full_s,
                        act_s[EXEC_W-KEY_W-1:2]};

endmodule

// File: tb/tb_netwalk_dataplane_subsystem.sv
// Directed bench for netwalk_dataplane_subsystem: forwarding, drop, rewrite
// priority, delete, ingress backpressure and the egress read handshake.
module tb_netwalk_dataplane_subsystem;

    logic         clk = 1'b0;
    logic         dpl_reset = 1'b1;
    logic [5:0]   prog_addr = 6'd0;
    logic [355:0] prog_data = '0;
    logic [355:0] prog_mask = '0;
    logic [371:0] exec_data = '0;
    logic         prog_en = 1'b0;
    logic         del_en = 1'b0;
    logic         in_rst = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_wr = 1'b0;
    logic         in_full;
    logic [127:0] eg_data;
    logic         eg_rd = 1'b0;
    logic         eg_empty;
    logic         eg_valid;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    netwalk_dataplane_subsystem dut (
        .dpl_clk              (clk),
        .dpl_reset            (dpl_reset),
        .dpl_program_addr     (prog_addr),
        .dpl_program_data     (prog_data),
        .dpl_program_mask     (prog_mask),
        .dpl_exec_data        (exec_data),
        .dpl_program_enable   (prog_en),
        .dpl_delete_enable    (del_en),
        .ingress_pcie_clk_i   (clk),
        .ingress_pcie_rst_i   (in_rst),
        .ingress_pcie_data_i  (in_data),
        .ingress_pcie_wr_en_i (in_wr),
        .ingress_pcie_full_o  (in_full),
        .egress_pcie_clk_i    (clk),
        .egress_pcie_data_o   (eg_data),
        .egress_pcie_rd_i     (eg_rd),
        .egress_pcie_empty_o  (eg_empty),
        .egress_pcie_valid_o  (eg_valid)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int k);
        return {32'h5A5A_0000 + 32'(k), 64'h0123_4567_89AB_CDEF, 32'(k)};
    endfunction

    task automatic send_word(input logic [127:0] w);
        in_wr   = 1'b1;
        in_data = w;
        @(negedge clk);
        in_wr   = 1'b0;
    endtask

    task automatic send_pkt(input logic [127:0] w0, input logic [127:0] w1, input logic [127:0] w2);
        send_word(w0);
        send_word(w1);
        send_word(w2);
    endtask

    task automatic read_word(input string tag, input logic [127:0] exp);
        int n = 0;
        while (eg_empty && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_avail"}, 128'(eg_empty), 128'd0);
        eg_rd = 1'b1;
        @(negedge clk);
        eg_rd = 1'b0;
        chk({tag, "_valid"}, 128'(eg_valid), 128'd1);
        chk({tag, "_data"}, eg_data, exp);
    endtask

    task automatic expect_pkt(input string tag, input logic [127:0] w0,
                              input logic [127:0] w1, input logic [127:0] w2);
        read_word({tag, "_w0"}, w0);
        read_word({tag, "_w1"}, w1);
        read_word({tag, "_w2"}, w2);
    endtask

    task automatic expect_empty(input string tag);
        repeat (40) @(negedge clk);
        chk(tag, 128'(eg_empty), 128'd1);
    endtask

    task automatic rule_op(input logic [5:0] addr, input logic [355:0] data, input logic [355:0] mask,
                           input logic [371:0] ex, input logic pe, input logic de);
        prog_addr = addr;
        prog_data = data;
        prog_mask = mask;
        exec_data = ex;
        prog_en   = pe;
        del_en    = de;
        @(negedge clk);
        prog_en   = 1'b0;
        del_en    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] a0, a1, a2, pw2;
        a0  = 128'h1111_2222_3333_4444_5555_6666_7777_8800;
        a1  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
        a2  = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
        pw2 = 128'hCAFE_BABE_DEAD_BEEF_0123_4567_89AB_CDEF;

        repeat (3) @(negedge clk);
        dpl_reset = 1'b0;
        @(negedge clk);
        chk("rst_empty", 128'(eg_empty), 128'd1);
        chk("rst_full",  128'(in_full),  128'd0);
        chk("rst_valid", 128'(eg_valid), 128'd0);
        chk("rst_data",  eg_data,        128'd0);

        // Empty table: a miss forwards unchanged.
        send_pkt(a0, a1, a2);
        expect_pkt("miss", a0, a1, a2);

        // Entry 5 drops headers whose low byte is 0xAB.
        rule_op(6'd5, 356'hAB, 356'hFF, {16'h0001, 356'd0}, 1'b1, 1'b0);
        send_pkt(128'h1111_2222_3333_4444_5555_6666_7777_88AB, a1, a2);
        expect_empty("drop_ab");
        send_pkt(128'h1111_2222_3333_4444_5555_6666_7777_88AC, a1, a2);
        expect_pkt("fwd_ac", 128'h1111_2222_3333_4444_5555_6666_7777_88AC, a1, a2);

        // Entry 2 (rewrite, match-all) beats entry 9 (drop, match-all).
        rule_op(6'd2, 356'd0, 356'd0, {16'h0002, 356'h1234}, 1'b1, 1'b0);
        rule_op(6'd9, 356'd0, 356'd0, {16'h0001, 356'd0}, 1'b1, 1'b0);
        send_pkt({128{1'b1}}, 128'h1111_1111_1111_1111_1111_1111_1111_1111, pw2);
        expect_pkt("prio", 128'h1234, 128'd0, 128'hCAFE_BAB0_0000_0000_0000_0000_0000_0000);

        // Deleting entry 2 exposes entry 9's drop; deleting 9 restores forwarding.
        rule_op(6'd2, 356'd0, 356'd0, 372'd0, 1'b0, 1'b1);
        send_pkt(a0, a1, a2);
        expect_empty("del2_drop9");
        rule_op(6'd9, 356'd0, 356'd0, 372'd0, 1'b0, 1'b1);
        send_pkt(a0, a1, a2);
        expect_pkt("del_fwd", a0, a1, a2);

        // Program and delete in the same cycle leaves the entry invalid.
        rule_op(6'd2, 356'd0, 356'd0, {16'h0002, 356'h1234}, 1'b1, 1'b1);
        send_pkt(a2, a1, a0);
        expect_pkt("pd_same", a2, a1, a0);

        // Read while empty produces no valid; a real pop is valid for one cycle only.
        eg_rd = 1'b1;
        @(negedge clk);
        eg_rd = 1'b0;
        chk("rd_empty_valid", 128'(eg_valid), 128'd0);
        send_pkt(a1, a2, a0);
        read_word("hs_w0", a1);
        @(negedge clk);
        chk("hs_valid_drop", 128'(eg_valid), 128'd0);
        read_word("hs_w1", a2);
        read_word("hs_w2", a0);

        // Fill egress with 5 packets so the FSM stalls, then overfill ingress.
        for (int k = 0; k < 15; k++) send_word(pat(100 + k));
        repeat (80) @(negedge clk);
        chk("bp_eg_nonempty", 128'(eg_empty), 128'd0);
        chk("bp_not_full",    128'(in_full),  128'd0);
        for (int k = 0; k < 17; k++) send_word(pat(200 + k));
        chk("bp_full", 128'(in_full), 128'd1);
        for (int k = 0; k < 15; k++) read_word($sformatf("bp_pre%0d", k), pat(100 + k));
        for (int k = 0; k < 15; k++) read_word($sformatf("bp_in%0d", k), pat(200 + k));
        expect_empty("bp_drained");
        chk("bp_full_clr", 128'(in_full), 128'd0);
        // Word 215 is stranded in ingress; word 216 was dropped, so 215 pairs with the next two.
        send_word(pat(300));
        send_word(pat(301));
        expect_pkt("bp_tail", pat(215), pat(300), pat(301));
        expect_empty("bp_final_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
